serial_sub: RTL
===============

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: W, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: c  input  1  clock; all state updates on posedge c.
REQ-003 Port: r  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operand pair a/b is valid.
REQ-005 Port: in_ready  output  1  block can accept an operand pair.
REQ-006 Port: a  input  W  minuend.
REQ-007 Port: b  input  W  subtrahend.
REQ-008 Port: out_valid  output  1  result y/borrow is valid.
REQ-009 Port: out_ready  input  1  consumer accepts the result.
REQ-010 Port: y  output  W  difference a - b.
REQ-011 Port: borrow  output  1  final borrow; 1 when a < b unsigned.

Function
REQ-012 The block SHALL be a bit-serial subtractor with three states: IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE: on a posedge with in_valid=1, the block SHALL latch a and b, clear the internal borrow and the bit counter, and move to RUN.
REQ-015 RUN: each cycle the block SHALL process one bit, LSB first.
- diff_i = a_i ^ b_i ^ br
- br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
- diff_i shifts into the result register.
REQ-016 RUN SHALL last exactly W cycles; after the W-th bit the block SHALL move to DONE.
REQ-017 out_valid SHALL assert exactly W posedges after the accepting posedge.
REQ-018 DONE: y and borrow SHALL hold stable until a posedge with out_ready=1; the block then SHALL return to IDLE.
REQ-019 There SHALL be no same-cycle turnaround: the next accept occurs at the earliest one posedge after the output handshake. Sustained throughput is one result per W+2 cycles.
REQ-020 in_valid, a and b SHALL be ignored outside IDLE.
REQ-021 Arithmetic SHALL be unsigned modulo 2^W; y equals (a - b) mod 2^W, subject to REQ-027.
REQ-022 y SHALL be driven only from the result register; no combinational path from a or b to y.
REQ-023 Outside DONE, y and borrow SHALL read 0.

Reset
REQ-024 A posedge with r=1 SHALL force IDLE and clear the operand, result, counter and borrow registers, regardless of in_valid or out_ready.
REQ-025 After reset: in_ready=1, out_valid=0, y=0, borrow=0.
REQ-026 Reset during RUN or DONE SHALL discard the operation; no result is ever presented for it.

Configuration
REQ-027 Macro SERIAL_SUB_SAT_EN:
- Defined: when the final borrow is 1, y SHALL present 0 (saturate at zero) and borrow still reports 1.
- Undefined: y SHALL present the wrapped two's-complement difference.

Verification
REQ-028 Basic subtract (W=8): a=0x05, b=0x03 -> y=0x02, borrow=0, out_valid exactly 8 posedges after accept.
REQ-029 Underflow: a=0x03, b=0x05 -> borrow=1; y=0xFE without SERIAL_SUB_SAT_EN, y=0x00 with it.
REQ-030 Edge operands:
- a=0xFF, b=0xFF -> y=0x00, borrow=0.
- a=0x00, b=0x01 -> y=0xFF (or 0x00 saturated), borrow=1.
- a=0x80, b=0x01 -> y=0x7F, borrow=0.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> y and borrow stable, in_ready=0, new operands not latched.
REQ-032 Reset mid-operation: assert r for 1 cycle after 3 RUN cycles -> next cycle in_ready=1, out_valid=0. A following a=0x10, b=0x01 then yields y=0x0F.
REQ-033 Streaming: in_valid and out_ready held 1 with 4 operand pairs -> 4 correct results, accepts spaced exactly 10 posedges apart (W+2).

Source files
------------

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial unsigned subtractor with valid/ready handshakes
//
// Computes y = (a - b) mod 2^W one bit per cycle, LSB first.
// Optional build macro SERIAL_SUB_SAT_EN: clamp y to zero when the final borrow is set.
//
// Ports:
//   c          clock, all state updates on posedge
//   r          synchronous active-high reset
//   in_valid   operand pair a/b valid (sampled only in IDLE)
//   in_ready   high only in IDLE
//   a, b       minuend / subtrahend, W bits
//   out_valid  high only in DONE
//   out_ready  consumer accepts y/borrow
//   y          difference, 0 outside DONE
//   borrow     final borrow (a < b), 0 outside DONE

module serial_sub #(
  parameter int W = 8
) (
  input  logic         c,
  input  logic         r,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         borrow
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   a_q, b_q, res_q;
  logic [CW-1:0]  cnt;
  logic           br;
  logic           diff_bit, br_n, last_bit;

  // One full-subtractor slice operating on the current LSBs of the shifting operands.
  assign diff_bit = a_q[0] ^ b_q[0] ^ br;
  assign br_n     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br);
  assign last_bit = (cnt == CW'(W - 1));

  always_ff @(posedge c) begin
    if (r) state <= IDLE;
    else   state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (last_bit) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge c) begin
    if (r) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt   <= '0;
      br    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
            cnt <= '0;
            br  <= 1'b0;
          end
        end
        RUN: begin
          // Operands shift right so bit 0 is always the bit in flight; the
          // result fills from the MSB end so it is aligned after W shifts.
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= {diff_bit, res_q[W-1:1]};
          br    <= br_n;
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    y      = '0;
    borrow = 1'b0;
    if (state == DONE) begin
      borrow = br;
`ifdef SERIAL_SUB_SAT_EN
      y = br ? '0 : res_q;
`else
      y = res_q;
`endif
    end
  end

endmodule
